sad_search_controller: RTL
==========================

# sad_search_controller

Sequencer for the block-matching motion-estimation datapath. It walks every candidate (row, column) offset of the search window and launches one SAD computation per candidate on the shared SAD engine. It tracks the running minimum SAD and its position, and reports the best match when the sweep finishes. It sits between the frame-level control (which issues Start) and the SAD engine plus the minimum-SAD result path.

## Interface
Parameters:
- SEARCH_ROWS, 49: number of candidate row offsets, legal range 1..256.
- SEARCH_COLS, 49: number of candidate column offsets, legal range 1..256.

Ports:
- Clk  input  1  single clock; all state changes on rising edge.
- Rst  input  1  synchronous, active-high reset.
- Start  input  1  launches a full search sweep when sampled high in IDLE or DONE.
- Busy  output  1  high from the cycle after an accepted Start until Done.
- Done  output  1  one-cycle pulse when the last candidate's SAD has been compared.
- SADStart  output  1  one-cycle pulse to the SAD engine; starts computation at CandRow/CandColumn.
- CandRow  output  8  current candidate row offset; stable from SADStart until the matching SADValid.
- CandColumn  output  8  current candidate column offset; same stability rule as CandRow.
- SADValid  input  1  SAD engine result strobe; one cycle.
- SADIn  input  32  SAD value for the current candidate; qualified by SADValid.
- MinSADOut  output  32  running or final minimum SAD.
- MinSADRowOut  output  8  row of MinSADOut.
- MinSADColumnOut  output  8  column of MinSADOut.
- ResultValid  output  1  high while the Min* outputs hold a completed sweep's result.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: Busy=0. On Start:
  - clear CandRow and CandColumn to 0
  - load MinSADOut=32'hFFFF_FFFF, MinSADRowOut=0, MinSADColumnOut=0
  - clear ResultValid
  - go to ISSUE.
- ISSUE: assert SADStart for exactly one cycle, then go to WAIT.
- WAIT: hold the candidate outputs and wait for SADValid. When SADValid=1:
  - If SADIn <= MinSADOut, load MinSADOut=SADIn, MinSADRowOut=CandRow and MinSADColumnOut=CandColumn. On ties the later candidate wins.
  - If this is the last candidate (CandRow=SEARCH_ROWS-1 and CandColumn=SEARCH_COLS-1), go to DONE.
  - Otherwise advance the candidate and go to ISSUE. The column is the inner loop: CandColumn increments. When CandColumn=SEARCH_COLS-1, it wraps to 0 and CandRow increments.
- DONE: Done=1 for this one cycle, ResultValid set to 1, Busy=0, then go to IDLE.
  - A Start sampled in DONE is accepted exactly as in IDLE and goes to ISSUE next cycle. The Done pulse still occurs.
- Start in ISSUE or WAIT: ignored. There is no queueing.
- SADValid outside WAIT: ignored. No min update, no candidate advance.
- SADIn comparison is a full 32-bit unsigned compare. The candidate counters are 8-bit and never exceed SEARCH_*-1.
- Min* outputs are registered and update only on a qualifying SADValid in WAIT, or on Start initialisation.
- ResultValid stays high until the next accepted Start or Rst.

## Timing
- Reset values (Rst high at a rising edge, takes priority over all inputs, in any state including mid-sweep):
  - state IDLE
  - Busy=0, Done=0, SADStart=0, ResultValid=0
  - CandRow=0, CandColumn=0
  - MinSADOut=32'hFFFF_FFFF, MinSADRowOut=0, MinSADColumnOut=0.
- Start sampled at edge N:
  - Busy=1 and SADStart=1 in cycle N+1.
  - State is WAIT from cycle N+2.
- SADValid sampled at edge M in WAIT:
  - Min* outputs are updated in cycle M+1.
  - Next SADStart in cycle M+1, or Done in cycle M+1 for the last candidate.
- Per-candidate cost is 1 + L cycles, where L is the SAD engine latency from SADStart to SADValid, with L>=1.
  - Minimum sweep: SEARCH_ROWS*SEARCH_COLS*(1+L)+1 cycles from Start to Done.
- SADValid in the same cycle as SADStart: ignored, because the state is ISSUE.
- Rst asserted during WAIT with SADValid high: reset wins and no update occurs.

## Test plan
- SEARCH_ROWS=2, SEARCH_COLS=3, L=2, SADIn sequence 50,40,60,40,70,90 -> candidates issued in order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2) -> Min=40 at (1,0) (tie, later wins); Done at cycle 6*3+1 after Start; ResultValid=1.
- Same parameters, all SADIn=32'hFFFF_FFFF -> Min=32'hFFFF_FFFF at (1,2), because every compare is <=.
- Start pulsed during WAIT of candidate (0,1) -> ignored; the sweep completes normally with exactly 6 SADStart pulses.
- Rst asserted in WAIT of candidate (1,0) -> next cycle: IDLE, all outputs at reset values. A subsequent Start runs a clean sweep from (0,0).
- SADValid pulsed in IDLE, and one cycle after Done -> no change to Min* or the candidate outputs.
- Start held high continuously -> a new sweep begins immediately after each Done. ResultValid clears in the cycle after the DONE-state Start. Each sweep issues 6 SADStart pulses.

Source files
------------

// File: rtl/sad_search_controller.sv
// Block-matching search sequencer: issues one SAD job per (row, column) candidate
// and keeps the smallest SAD and its position (later candidates win ties).
`timescale 1ns/1ps
module sad_search_controller #(
  parameter int SEARCH_ROWS = 49,
  parameter int SEARCH_COLS = 49
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  output logic        Busy,
  output logic        Done,
  output logic        SADStart,
  output logic [7:0]  CandRow,
  output logic [7:0]  CandColumn,
  input  logic        SADValid,
  input  logic [31:0] SADIn,
  output logic [31:0] MinSADOut,
  output logic [7:0]  MinSADRowOut,
  output logic [7:0]  MinSADColumnOut,
  output logic        ResultValid
);

  localparam logic [7:0] LAST_ROW = 8'(SEARCH_ROWS - 1);
  localparam logic [7:0] LAST_COL = 8'(SEARCH_COLS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t state, state_d;
  logic   accept;
  logic   take;
  logic   last_cand;

  assign last_cand = (CandRow == LAST_ROW) && (CandColumn == LAST_COL);

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d  = state;
    Busy     = 1'b0;
    Done     = 1'b0;
    SADStart = 1'b0;
    accept   = 1'b0;
    take     = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        Busy     = 1'b1;
        SADStart = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        Busy = 1'b1;
        if (SADValid) begin
          take    = 1'b1;
          state_d = last_cand ? DONE : ISSUE;
        end
      end
      DONE: begin
        Done = 1'b1;
        if (Start) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ResultValid rises together with Done so the result is usable in the Done cycle.
  always_ff @(posedge Clk) begin
    if (Rst || accept) begin
      CandRow         <= '0;
      CandColumn      <= '0;
      MinSADOut       <= '1;
      MinSADRowOut    <= '0;
      MinSADColumnOut <= '0;
      ResultValid     <= 1'b0;
    end else if (take) begin
      if (SADIn <= MinSADOut) begin
        MinSADOut       <= SADIn;
        MinSADRowOut    <= CandRow;
        MinSADColumnOut <= CandColumn;
      end
      if (last_cand) begin
        ResultValid <= 1'b1;
      end else if (CandColumn == LAST_COL) begin
        CandColumn <= '0;
        CandRow    <= CandRow + 8'd1;
      end else begin
        CandColumn <= CandColumn + 8'd1;
      end
    end
  end

endmodule
